// File: rtl/coin_front_end_if.sv
// Coin front-end bus: raw sensor levels in, cleaned coin codes and status out.
// slave  : the coin_front_end side (samples sensors, drives codes).
// master : the environment side (drives sensors, observes codes).
interface coin_front_end_if;
  logic       coin5_raw;
  logic       coin10_raw;
  logic [1:0] din;
  logic       coin_err;
  logic [2:0] pending;

  modport master (
    output coin5_raw,
    output coin10_raw,
    input  din,
    input  coin_err,
    input  pending
  );

  modport slave (
    input  coin5_raw,
    input  coin10_raw,
    output din,
    output coin_err,
    output pending
  );
endinterface

// File: rtl/coin_front_end.sv
// coin_front_end: synchronizes and debounces two asynchronous coin sensors,
// queues accepted coins in arrival order and issues them to the vending FSM
// as single-cycle codes (2'b10 = 5-unit, 2'b11 = 10-unit), each followed by
// MIN_GAP idle cycles and one IDLE pop cycle.
//
// Build option COIN_FIFO_QUEUE_EN:
//   defined   - 4-entry coin FIFO, pending 0..4
//   undefined - single holding register, pending 0..1
module coin_front_end #(
  parameter int unsigned DEB_CYCLES = 4,  // 1..255
  parameter int unsigned MIN_GAP    = 2   // 1..15
) (
  input  logic             clock,
  input  logic             rst,
  coin_front_end_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [7:0] DEB_LIMIT = 8'(DEB_CYCLES);
  localparam logic [3:0] GAP_LOAD  = 4'(MIN_GAP - 1);

  // Channel 0 is the 5-unit sensor, channel 1 the 10-unit sensor.
  logic [1:0] raw;
  logic [1:0] rise;

  logic       pop;
  logic       q_empty;
  logic       head_type;   // 1 = 10-unit coin at the queue head
  logic       acc10;
  logic       acc5;
  logic       drop;
  logic [2:0] pending;

  logic [1:0] state;
  logic [3:0] gap_cnt;
  logic [1:0] din_q;
  logic       coin_err_q;

  assign raw = {bus.coin10_raw, bus.coin5_raw};

  // ------------------------------------------------------------------------
  // Per-channel synchronizer and debounce
  // ------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic       meta;
    logic       sync;
    logic       stable;
    logic       rise_q;
    logic [7:0] cnt;

    // Two-flop synchronizer, then count mismatch cycles until the stable
    // level flips; a 0->1 flip produces a one-cycle rise pulse.
    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        meta   <= 1'b0;
        sync   <= 1'b0;
        stable <= 1'b0;
        rise_q <= 1'b0;
        cnt    <= '0;
      end else begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of its neighbour (meta -> sync is a real 2-stage chain).
        meta   <= raw[g];
        sync   <= meta;
        rise_q <= 1'b0;
        if (cnt == DEB_LIMIT) begin
          stable <= ~stable;
          rise_q <= ~stable;
          cnt    <= '0;
        end else if (sync != stable) begin
          cnt <= cnt + 8'd1;
        end else begin
          cnt <= '0;
        end
      end
    end

    assign rise[g] = rise_q;
  end

  // The sequencer pops only from IDLE when something is waiting.
  assign pop = (state == ST_IDLE) && !q_empty;

  // ------------------------------------------------------------------------
  // Coin queue
  // ------------------------------------------------------------------------
`ifdef COIN_FIFO_QUEUE_EN
  logic       mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;
  logic [2:0] free;

  assign q_empty   = (count == 3'd0);
  assign head_type = mem[rd_ptr];
  assign wr_ptr    = rd_ptr + count[1:0];
  assign pending   = count;

  // Slots available this cycle, counting the one freed by a pop; the
  // 10-unit coin claims a slot first so it survives a shortage.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise
    // synthesis would infer latches for the unassigned cases.
    free  = 3'd4 - count + {2'b00, pop};
    acc10 = 1'b0;
    acc5  = 1'b0;
    if (rise[1] && (free != 3'd0)) acc10 = 1'b1;
    if (rise[0] && (free > {2'b00, acc10})) acc5 = 1'b1;
  end

  // Coin-type storage; 10 is written before 5 when both arrive together.
  // NOTE: the storage array has no reset; clearing count and rd_ptr
  // discards its contents, and leaving it unreset keeps it plain RAM/flops.
  always_ff @(posedge clock) begin
    if (acc10) mem[wr_ptr] <= 1'b1;
    if (acc5)  mem[wr_ptr + {1'b0, acc10}] <= 1'b0;
  end

  // Read pointer and occupancy.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + {1'b0, pop};
      count  <= count - {2'b00, pop} + {2'b00, acc10} + {2'b00, acc5};
    end
  end
`else
  logic hold_valid;
  logic hold_type;
  logic hold_free;

  assign q_empty   = !hold_valid;
  assign head_type = hold_type;
  assign pending   = {2'b00, hold_valid};

  // The holding register takes at most one coin per cycle, 10 first.
  always_comb begin
    hold_free = !hold_valid || pop;
    acc10     = rise[1] && hold_free;
    acc5      = rise[0] && hold_free && !rise[1];
  end

  // Single-entry holding register.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_type  <= 1'b0;
    end else if (acc10 || acc5) begin
      hold_valid <= 1'b1;
      hold_type  <= acc10;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  // Any rising event that found no room is a drop.
  assign drop = (rise[1] && !acc10) || (rise[0] && !acc5);

  // Drop flag, aligned with the attempted push.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) coin_err_q <= 1'b0;
    else      coin_err_q <= drop;
  end

  // ------------------------------------------------------------------------
  // Sequencer: IDLE pop -> EMIT (code out) -> GAP (MIN_GAP zero cycles)
  // ------------------------------------------------------------------------
  // Registered code output with guaranteed idle spacing between coins.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      din_q   <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            din_q <= {1'b1, head_type};
            state <= ST_EMIT;
          end else begin
            din_q <= 2'b00;
          end
        end
        ST_EMIT: begin
          din_q   <= 2'b00;
          gap_cnt <= GAP_LOAD;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          din_q <= 2'b00;
          if (gap_cnt == 4'd0) state <= ST_IDLE;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: begin
          din_q <= 2'b00;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.din      = din_q;
  assign bus.coin_err = coin_err_q;
  assign bus.pending  = pending;

endmodule

// File: tb/tb_coin_front_end.sv
// Testbench for coin_front_end. Two instances share the same sensor stimulus:
//   dut_a : DEB_CYCLES=4, MIN_GAP=2   (nominal timing)
//   dut_b : DEB_CYCLES=1, MIN_GAP=15  (fast acceptance, long gap -> overflow)
// A cycle-level reference model built from the coin rules (sample delay,
// mismatch run length, coin list, issue hold-off) is compared every cycle.
module tb_coin_front_end;

  localparam int DEB_A = 4;
  localparam int GAP_A = 2;
  localparam int DEB_B = 1;
  localparam int GAP_B = 15;
`ifdef COIN_FIFO_QUEUE_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic raw5  = 1'b0;
  logic raw10 = 1'b0;

  always #5 clock = ~clock;

  coin_front_end_if bus_a ();
  coin_front_end_if bus_b ();

  assign bus_a.coin5_raw  = raw5;
  assign bus_a.coin10_raw = raw10;
  assign bus_b.coin5_raw  = raw5;
  assign bus_b.coin10_raw = raw10;

  coin_front_end #(.DEB_CYCLES(DEB_A), .MIN_GAP(GAP_A)) dut_a (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_a)
  );

  coin_front_end #(.DEB_CYCLES(DEB_B), .MIN_GAP(GAP_B)) dut_b (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: index [inst][channel], channel 0 = 5-unit, 1 = 10-unit
  // ------------------------------------------------------------------------
  int m_deb [2] = '{DEB_A, DEB_B};
  int m_gap [2] = '{GAP_A, GAP_B};
  int m_ff1    [2][2];
  int m_s      [2][2];
  int m_stable [2][2];
  int m_run    [2][2];
  int m_rise   [2][2];
  int m_q      [2][$];   // coin values (5 or 10) in arrival order
  int m_hold   [2];      // cycles before the next issue is allowed
  int m_din    [2];
  int m_err    [2];
  int m_pend   [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        m_ff1[i][c] = 0; m_s[i][c] = 0; m_stable[i][c] = 0;
        m_run[i][c] = 0; m_rise[i][c] = 0;
      end
      m_q[i].delete();
      m_hold[i] = 0; m_din[i] = 0; m_err[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int raw [2];
    int ev5;
    int ev10;
    raw[0] = int'(raw5);
    raw[1] = int'(raw10);
    ev5  = m_rise[i][0];
    ev10 = m_rise[i][1];
    // issue: one coin, then a hold-off of MIN_GAP zero cycles plus the pop cycle
    if (m_hold[i] == 0 && m_q[i].size() > 0) begin
      m_din[i]  = (m_q[i].pop_front() == 10) ? 3 : 2;
      m_hold[i] = m_gap[i] + 1;
    end else begin
      m_din[i] = 0;
      if (m_hold[i] > 0) m_hold[i]--;
    end
    // store coins that fit, the 10-unit coin first
    m_err[i] = 0;
    if (ev10 != 0) begin
      if (m_q[i].size() < CAP) m_q[i].push_back(10);
      else m_err[i] = 1;
    end
    if (ev5 != 0) begin
      if (m_q[i].size() < CAP) m_q[i].push_back(5);
      else m_err[i] = 1;
    end
    m_pend[i] = m_q[i].size();
    // debounce on the synchronized sample, then advance the sample delay
    for (int c = 0; c < 2; c++) begin
      m_rise[i][c] = 0;
      if (m_run[i][c] == m_deb[i]) begin
        m_stable[i][c] = 1 - m_stable[i][c];
        m_rise[i][c]   = m_stable[i][c];
        m_run[i][c]    = 0;
      end else if (m_s[i][c] != m_stable[i][c]) begin
        m_run[i][c]++;
      end else begin
        m_run[i][c] = 0;
      end
      m_s[i][c]   = m_ff1[i][c];
      m_ff1[i][c] = raw[c];
    end
  endtask

  always @(posedge clock or negedge rst) begin
    if (!rst) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (rst) begin
      check("din_a",     bus_a.din,      m_din[0]);
      check("err_a",     bus_a.coin_err, m_err[0]);
      check("pending_a", bus_a.pending,  m_pend[0]);
      check("din_b",     bus_b.din,      m_din[1]);
      check("err_b",     bus_b.coin_err, m_err[1]);
      check("pending_b", bus_b.pending,  m_pend[1]);
    end
  end

  // Observation counters for the directed scenarios.
  int a_n10 = 0, a_n11 = 0, a_pmax = 0;
  int b_codes = 0, b_errs = 0, mb_codes = 0, mb_errs = 0;

  always @(negedge clock) begin
    if (rst) begin
      if (bus_a.din == 2'b11) a_n11++;
      if (bus_a.din == 2'b10) a_n10++;
      if (int'(bus_a.pending) > a_pmax) a_pmax = int'(bus_a.pending);
      if (bus_b.din != 2'b00) b_codes++;
      if (bus_b.coin_err) b_errs++;
      if (m_din[1] != 0) mb_codes++;
      if (m_err[1] != 0) mb_errs++;
    end
  end

  task automatic clear_obs();
    a_n10 = 0; a_n11 = 0; a_pmax = 0;
    b_codes = 0; b_errs = 0; mb_codes = 0; mb_errs = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_din_a"},     bus_a.din,      0);
    check({tag, "_err_a"},     bus_a.coin_err, 0);
    check({tag, "_pending_a"}, bus_a.pending,  0);
    check({tag, "_din_b"},     bus_b.din,      0);
    check({tag, "_err_b"},     bus_b.coin_err, 0);
    check({tag, "_pending_b"}, bus_b.pending,  0);
  endtask

  // Raw high before edge 0 -> dut_a code visible only after edge 4+DEB_A.
  task automatic check_single_code(input string tag);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clock);
      check(tag, bus_a.din, (k == DEB_A + 4) ? 2 : 0);
    end
  endtask

  initial begin
    int h5;
    int h10;

    // reset state
    cycles(3);
    check_zero_outputs("reset");
    #2 rst = 1'b1;
    cycles(10);

    // single 5-unit coin, 20 cycles high
    raw5 = 1'b1;
    check_single_code("single5_din_a");
    cycles(7);
    raw5 = 1'b0;
    cycles(40);
    check("single5_pending_a", bus_a.pending, 0);

    // bounce rejection on the 10-unit sensor (dut_a), then a real coin
    clear_obs();
    for (int p = 0; p < 4; p++) begin
      raw10 = 1'b1; cycles(3);
      raw10 = 1'b0; cycles(3);
    end
    cycles(20);
    check("bounce_none_a", a_n11, 0);
    raw10 = 1'b1; cycles(6);
    raw10 = 1'b0; cycles(40);
    check("bounce_one_a", a_n11, 1);
    cycles(80);

    // simultaneous coins on dut_a
    clear_obs();
    raw5 = 1'b1; raw10 = 1'b1;
    cycles(10);
    raw5 = 1'b0; raw10 = 1'b0;
    cycles(40);
    check("simul_n11_a", a_n11, 1);
    check("simul_n10_a", a_n10, (CAP > 1) ? 1 : 0);
    check("simul_pmax_a", a_pmax, (CAP > 1) ? 2 : 1);
    cycles(40);

    // overflow on dut_b (long gap, fast debounce)
    clear_obs();
    for (int p = 0; p < 4; p++) begin
      raw5 = 1'b1; raw10 = 1'b1; cycles(3);
      raw5 = 1'b0; raw10 = 1'b0; cycles(3);
    end
    cycles(180);
    check("ovf_codes_b", b_codes, mb_codes);
    check("ovf_errs_b", b_errs, mb_errs);
    check("ovf_err_seen_b", (b_errs > 0) ? 1 : 0, 1);

    // reset mid-operation with coins waiting in dut_b
    for (int p = 0; p < 3; p++) begin
      raw5 = 1'b1; raw10 = 1'b1; cycles(3);
      raw5 = 1'b0; raw10 = 1'b0; cycles(3);
    end
    #2 rst = 1'b0;
    #1 check_zero_outputs("midreset");
    cycles(3);
    #2 rst = 1'b1;
    clear_obs();
    cycles(60);
    check("after_reset_codes_b", b_codes, 0);
    check("after_reset_codes_a", a_n10 + a_n11, 0);

    // coin held high across reset release
    raw5 = 1'b1;
    cycles(1);
    #2 rst = 1'b0;
    cycles(3);
    #2 rst = 1'b1;
    check_single_code("held_reset_din_a");
    raw5 = 1'b0;
    cycles(60);

    // randomized sensor activity: random hold lengths give both bounce and coins
    h5 = 0;
    h10 = 0;
    for (int t = 0; t < 3000; t++) begin
      if (h5 == 0) begin
        raw5 = ~raw5;
        h5 = int'($urandom_range(1, 12));
      end
      if (h10 == 0) begin
        raw10 = ~raw10;
        h10 = int'($urandom_range(1, 12));
      end
      h5--;
      h10--;
      cycles(1);
    end
    raw5 = 1'b0;
    raw10 = 1'b0;
    cycles(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
